// File: rtl/io_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce_pkg
// Description : Shared constants and width helpers for the io_debounce block.
// Revision    : 1.0 - initial release
// ============================================================================
package io_debounce_pkg;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_TICK_DIV     = 100000;  // 1 ms tick at 100 MHz
  localparam int DEF_STABLE_TICKS = 10;

  // Stable-sample counter width: ceil(log2(stable_ticks)) + 1 bits
  function automatic int cnt_width(input int stable_ticks);
    return ((stable_ticks > 1) ? $clog2(stable_ticks) : 0) + 1;
  endfunction

  // Prescaler width, never less than one bit
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: 2-flop synchronizer, saturating stable
//               counter, accepted level and registered edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
  import io_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Bring the asynchronous pin into the clock domain before anything looks at it
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // On each tick: count consecutive differing samples, accept after STABLE_TICKS
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Edge pulses come from comparing level against its one-cycle-old copy
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : Multi-channel pin debouncer with shared sample-tick prescaler
//               and a sticky change-event latch.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce
  import io_debounce_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             evt_clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_pending,
  output logic [WIDTH-1:0] evt_mask
);

  localparam int            PW       = div_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] edges;
  logic             any_edge;

  // Prescaler: tick is high for the one cycle in which the count sits at 0
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk_100mhz (clk_100mhz),
      .rst_n      (rst_n),
      .raw        (raw_in[i]),
      .tick       (tick),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i])
    );
  end

  assign edges    = rise | fall;
  assign any_edge = |edges;

  // Sticky event latch; a new edge in the clear cycle survives the clear
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      evt_pending <= 1'b0;
      evt_mask    <= '0;
    end else if (evt_clr) begin
      evt_pending <= any_edge;
      evt_mask    <= edges;
    end else begin
      evt_pending <= evt_pending | any_edge;
      evt_mask    <= evt_mask | edges;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_debounce
// Description : Scoreboard bench for io_debounce (TICK_DIV=4, STABLE_TICKS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_debounce;

  typedef struct packed {
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] level;
  } exp_t;

  logic        clk_100mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [15:0] raw_in     = '0;
  logic        evt_clr    = 1'b0;
  logic [15:0] level, rise, fall, evt_mask;
  logic        evt_pending;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  io_debounce #(
    .WIDTH        (16),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .evt_clr     (evt_clr),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .evt_pending (evt_pending),
    .evt_mask    (evt_mask)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  // Wait (bounded) until the masked level equals v; n returns cycles waited
  task automatic wait_lvl(input logic [15:0] m, input logic [15:0] v, input int maxc, output int n);
    n = 0;
    while (((level & m) != v) && (n < maxc)) begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end
  endtask

  task automatic pulse_clr();
    evt_clr = 1'b1;
    cyc(1);
    evt_clr = 1'b0;
    cyc(1);
  endtask

  // Monitor: every cycle with any edge pulse must match the next scoreboard entry
  always @(negedge clk_100mhz) begin
    if (rst_n && ((rise | fall) != 16'h0)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_edge", {rise, fall}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rise",  {16'h0, rise},  {16'h0, e.rise});
        check("sb_fall",  {16'h0, fall},  {16'h0, e.fall});
        check("sb_level", {16'h0, level}, {16'h0, e.level});
      end
    end
  end

  initial begin
    int n;

    // Reset state
    cyc(3);
    check("rst_level",   {16'h0, level},    32'h0);
    check("rst_rise",    {16'h0, rise},     32'h0);
    check("rst_fall",    {16'h0, fall},     32'h0);
    check("rst_pending", {31'h0, evt_pending}, 32'h0);
    check("rst_mask",    {16'h0, evt_mask}, 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Single channel accepted rise
    raw_in = 16'h0001;
    sb_q.push_back('{rise: 16'h0001, fall: 16'h0, level: 16'h0001});
    wait_lvl(16'h0001, 16'h0001, 40, n);
    check("t1_latency_ok", {31'h0, (n >= 10 && n <= 18)}, 32'h1);
    check("t1_level", {16'h0, level}, 32'h0001);
    cyc(3);
    check("t1_pending", {31'h0, evt_pending}, 32'h1);
    check("t1_mask",    {16'h0, evt_mask},    32'h0001);

    // Glitch of two ticks on channel 3 must be ignored
    raw_in = 16'h0009;
    cyc(8);
    raw_in = 16'h0001;
    cyc(20);
    check("t2_level", {16'h0, level},    32'h0001);
    check("t2_mask",  {16'h0, evt_mask}, 32'h0001);
    pulse_clr();
    check("clr_pending", {31'h0, evt_pending}, 32'h0);
    check("clr_mask",    {16'h0, evt_mask},    32'h0);

    // Return to all-low, then all channels rise together
    raw_in = 16'h0000;
    sb_q.push_back('{rise: 16'h0, fall: 16'h0001, level: 16'h0000});
    wait_lvl(16'hFFFF, 16'h0000, 40, n);
    cyc(3);
    pulse_clr();
    raw_in = 16'hFFFF;
    sb_q.push_back('{rise: 16'hFFFF, fall: 16'h0, level: 16'hFFFF});
    wait_lvl(16'hFFFF, 16'hFFFF, 40, n);
    check("t3_level", {16'h0, level}, 32'hFFFF);
    cyc(3);
    check("t3_pending", {31'h0, evt_pending}, 32'h1);
    check("t3_mask",    {16'h0, evt_mask},    32'hFFFF);

    // Clear coincident with fall[5]: the new edge wins
    raw_in = 16'hFFDF;
    sb_q.push_back('{rise: 16'h0, fall: 16'h0020, level: 16'hFFDF});
    wait_lvl(16'h0020, 16'h0000, 40, n);
    cyc(1);          // fall[5] now visible
    evt_clr = 1'b1;
    cyc(1);
    evt_clr = 1'b0;
    check("t4_pending", {31'h0, evt_pending}, 32'h1);
    check("t4_mask",    {16'h0, evt_mask},    32'h0020);
    cyc(2);
    pulse_clr();
    check("t4_clr_pending", {31'h0, evt_pending}, 32'h0);
    check("t4_clr_mask",    {16'h0, evt_mask},    32'h0);

    // Reset mid-count discards the partial count
    raw_in = 16'h0000;
    sb_q.push_back('{rise: 16'h0, fall: 16'hFFDF, level: 16'h0000});
    wait_lvl(16'hFFFF, 16'h0000, 40, n);
    cyc(3);
    raw_in = 16'h0001;
    cyc(9);          // two ticks' worth of counting in progress
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_level",   {16'h0, level},    32'h0);
    check("t5_rst_mask",    {16'h0, evt_mask}, 32'h0);
    check("t5_rst_pending", {31'h0, evt_pending}, 32'h0);
    cyc(3);
    #2 rst_n = 1'b1;
    sb_q.push_back('{rise: 16'h0001, fall: 16'h0, level: 16'h0001});
    wait_lvl(16'h0001, 16'h0001, 40, n);
    check("t5_latency_ok", {31'h0, (n >= 12 && n <= 16)}, 32'h1);
    cyc(20);

    check("sb_drained", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/io_debounce.md
IO_DEBOUNCE -- requirements
Module: io_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of raw input channels.
REQ-002 The block SHALL have parameter TICK_DIV, default 100000, giving clk_100mhz cycles per sample tick (1 ms at 100 MHz).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 10, giving consecutive equal samples required to accept a new level.
REQ-004 The block SHALL have port clk_100mhz, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port raw_in, input, WIDTH bits: asynchronous button/switch pins.
REQ-007 The block SHALL have port evt_clr, input, 1 bit: one-cycle pulse that clears evt_pending.
REQ-008 The block SHALL have port level, output, WIDTH bits: debounced level per channel.
REQ-009 The block SHALL have port rise, output, WIDTH bits: one-cycle pulse on an accepted 0->1 change.
REQ-010 The block SHALL have port fall, output, WIDTH bits: one-cycle pulse on an accepted 1->0 change.
REQ-011 The block SHALL have port evt_pending, output, 1 bit: sticky flag for any accepted change.
REQ-012 The block SHALL have port evt_mask, output, WIDTH bits: sticky OR of channels that changed since the last clear.

Function
REQ-013 Each raw_in bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle when it wraps to 0.
REQ-015 On tick, per channel: if the synchronized sample equals level, the stable counter SHALL reset to 0; otherwise it SHALL increment.
REQ-016 When the counter reaches STABLE_TICKS-1 while the sample still differs, level SHALL toggle on that tick cycle and the counter SHALL reset to 0.
REQ-017 A glitch shorter than STABLE_TICKS ticks SHALL produce no change in level, rise, fall or evt_*.
REQ-018 rise/fall SHALL assert in the cycle after level changes, for exactly one cycle, from a registered edge compare.
REQ-019 Per-channel counters SHALL be ceil(log2(STABLE_TICKS))+1 bits wide and SHALL saturate, never wrap.
REQ-020 evt_pending SHALL set on any rise|fall; evt_mask SHALL OR in rise|fall.
REQ-021 If evt_clr and a new rise|fall coincide, set SHALL win: evt_pending=1, evt_mask=new edges only.
REQ-022 evt_clr with no coincident edge SHALL zero evt_pending and evt_mask on the next edge.
REQ-023 Simultaneous changes on several channels SHALL be reported in the same cycle with no loss.

Reset
REQ-024 On rst_n low, all of the following SHALL clear to 0 asynchronously: synchronizers, prescaler, counters, level, rise, fall, evt_pending and evt_mask.
REQ-025 Upon rst_n release, the first accepted level SHALL require the full STABLE_TICKS; pins held high through reset SHALL produce one rise.
REQ-026 Reset asserted mid-count SHALL discard partial counts and produce no pulses.

Structure
REQ-027 Default TICK_DIV/STABLE_TICKS constants and the counter-width function SHALL reside in the shared io package.
REQ-028 Per-channel logic (counter, level, edge register) SHALL be a sub-module debounce_chan, instantiated WIDTH times; the prescaler and event latch SHALL stay in io_debounce.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-029 Stimulus: raw_in[0] 0->1, held. Required: level[0]=1 within 2+3*4 cycles (+1 tick phase), then rise[0] one cycle, evt_pending=1, evt_mask=0x0001.
REQ-030 Stimulus: raw_in[3] high for 2 ticks, then low. Required: level, rise, fall and evt_* all unchanged.
REQ-031 Stimulus: raw_in=0xFFFF at once. Required: rise=0xFFFF in a single cycle, evt_mask=0xFFFF.
REQ-032 Stimulus: evt_clr coincident with fall[5]. Required: evt_pending=1, evt_mask=0x0020; then evt_clr alone gives 0, 0x0000.
REQ-033 Stimulus: rst_n pulsed low mid-count with raw_in=0x0001. Required: outputs 0 immediately; rise[0] exactly once, a full 3 ticks after release.
